// File: rtl/uart_rx_stream.sv
// uart_rx_stream: UART frame deserialiser with one-word valid/ready holding register.
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   rx        asynchronous serial line, idles high
//   m_data    received word, held while m_valid
//   m_valid   m_data holds an unconsumed word
//   m_ready   consumer accepts on m_valid && m_ready
//   frame_err one-cycle pulse: stop bit sampled low
//   overrun   one-cycle pulse: word completed while holding register full
module uart_rx_stream #(
  parameter int CLOCKS_PER_PULSE = 2604,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overrun
);
  localparam int HALF = CLOCKS_PER_PULSE / 2;
  localparam int CW   = $clog2(CLOCKS_PER_PULSE);
  localparam int IW   = BITS_PER_WORD > 1 ? $clog2(BITS_PER_WORD) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, last_cnt;
  logic [IW-1:0]            bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                     valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                     rx_meta_q, rx_s_q, samp, deliver;
  assign last_cnt  = state_q == START ? CW'(HALF - 1) : CW'(CLOCKS_PER_PULSE - 1);
  assign samp      = cnt_q == last_cnt;
  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = samp ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : START;
      end
      START: begin
        bit_d = '0;
        if (samp) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (samp) begin
        // right shift so the first (LSB) bit ends up at bit 0
        shreg_d = BITS_PER_WORD'({rx_s_q, shreg_q} >> 1);
        bit_d   = bit_q + IW'(1);
        if (bit_q == IW'(BITS_PER_WORD - 1)) state_d = STOP;
      end
      STOP: if (samp) begin
        deliver = rx_s_q;
        ferr_d  = !rx_s_q;
        state_d = rx_s_q ? IDLE : BREAK;
      end
      BREAK: begin
        // a held-low line must not be parsed as back-to-back frames
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
    if (deliver && (!valid_q || m_ready)) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
    end else begin
      ovr_d = deliver;
      if (valid_q && m_ready) valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end
endmodule
